// File: rtl/vga_timing_pkg.sv
// Shared pixel type, default 640x480@60 timing, total-period helper and the
// colour-bar palette used by the scanout test pattern.
package vga_timing_pkg;

  localparam int PIXEL_W = 24;
  typedef logic [PIXEL_W-1:0] pixel_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Left-to-right bar order across the active width.
  localparam pixel_t BAR_COLOURS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/vga_timing_counter.sv
// Free-running h/v raster counters with raw (unpipelined) sync, data enable and
// horizontal active flag. Reset parks the raster two lines before the frame top.
module vga_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int H_W      = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int V_W      = $clog2(timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic           clock,
  input  logic           reset_n,
  output logic [H_W-1:0] h_o,
  output logic [V_W-1:0] v_o,
  output logic           hsync_raw_o,
  output logic           vsync_raw_o,
  output logic           de_raw_o,
  output logic           h_active_o
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_START  = V_W'(V_TOTAL - 2);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= V_START;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o         = h_q;
  assign v_o         = v_q;
  assign h_active_o  = (h_q < H_ACT);
  assign de_raw_o    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hsync_raw_o = !((h_q >= HS_START) && (h_q < HS_END));
  assign vsync_raw_o = !((v_q >= VS_START) && (v_q < VS_END));

endmodule

// File: rtl/row_scanout.sv
// VGA scanout of a ping-pong row buffer with pixel/line doubling, row swaps and
// renderer requests. Define SCANOUT_TEST_PATTERN_EN to replace pixels with colour bars.
module row_scanout
  import vga_timing_pkg::*;
#(
  parameter int A           = 9,
  parameter int S           = PIXEL_W,
  parameter int R           = 9,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int SCALE_SHIFT = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  output logic [A-1:0] address_read,
  input  logic [S-1:0] data_read,
  output logic         swap,
  output logic         line_req,
  output logic [R-1:0] line_row,
  input  logic         line_done,
  output logic [S-1:0] rgb,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic         underrun
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_PRIME  = V_W'(V_TOTAL - 2);
  localparam logic [V_W-1:0] SRC_ROWS = V_W'(V_ACTIVE >> SCALE_SHIFT);
  localparam logic [V_W-1:0] ROW_MASK = V_W'((1 << SCALE_SHIFT) - 1);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;
  logic           hs_raw, vs_raw, de_raw, h_active;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .H_W      (H_W),      .V_W  (V_W)
  ) u_timing (
    .clock       (clock),
    .reset_n     (reset_n),
    .h_o         (h_cnt),
    .v_o         (v_cnt),
    .hsync_raw_o (hs_raw),
    .vsync_raw_o (vs_raw),
    .de_raw_o    (de_raw),
    .h_active_o  (h_active)
  );

  assign address_read = h_active ? A'(h_cnt >> SCALE_SHIFT) : '0;

  // Renderer handshake: line_req is a one-cycle pulse that marks line_row as
  // pending; a one-cycle line_done retires it. A request in the same cycle as a
  // done keeps the new request pending. Swaps never wait on the renderer.
  logic [V_W-1:0] l_next, src_row;
  logic           at_row_end, is_prime, is_boundary, want_req;
  logic           swap_q, swap_d, line_req_q, line_req_d;
  logic [R-1:0]   line_row_q, line_row_d;
  logic           pending_q, pending_d, underrun_q, underrun_d;

  always_comb begin
    l_next      = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    src_row     = l_next >> SCALE_SHIFT;
    at_row_end  = (h_cnt == H_ACT);
    is_prime    = at_row_end && (v_cnt == V_PRIME);
    is_boundary = at_row_end && (l_next < V_ACT) && ((l_next & ROW_MASK) == '0);
    want_req    = is_prime || (is_boundary && ((src_row + 1'b1) < SRC_ROWS));
    swap_d      = is_boundary;
    line_req_d  = want_req;
    line_row_d  = line_row_q;
    if (is_prime) begin
      line_row_d = '0;
    end else if (want_req) begin
      line_row_d = R'(src_row + 1'b1);
    end
    pending_d  = line_req_q | (pending_q & ~line_done);
    underrun_d = underrun_q | (swap_q & pending_q);
  end

  // Stage 1 aligns raster flags with data_read; stage 2 is the pin register.
  logic         de1_q, hs1_q, vs1_q;
  logic         de_q, hsync_q, vsync_q;
  logic [S-1:0] rgb_q, rgb_d;

`ifdef SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  logic [2:0] bar_d, bar1_q;

  always_comb begin
    bar_d = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_cnt) >= k * BAR_W) bar_d = 3'(k);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) bar1_q <= '0;
    else          bar1_q <= bar_d;
  end

  assign rgb_d = de1_q ? S'(BAR_COLOURS[bar1_q]) : '0;
`else
  assign rgb_d = de1_q ? data_read : '0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      de1_q      <= 1'b0;
      hs1_q      <= 1'b1;
      vs1_q      <= 1'b1;
      de_q       <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= '0;
      swap_q     <= 1'b0;
      line_req_q <= 1'b0;
      line_row_q <= '0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      de1_q      <= de_raw;
      hs1_q      <= hs_raw;
      vs1_q      <= vs_raw;
      de_q       <= de1_q;
      hsync_q    <= hs1_q;
      vsync_q    <= vs1_q;
      rgb_q      <= rgb_d;
      swap_q     <= swap_d;
      line_req_q <= line_req_d;
      line_row_q <= line_row_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
    end
  end

  assign rgb      = rgb_q;
  assign de       = de_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign swap     = swap_q;
  assign line_req = line_req_q;
  assign line_row = line_row_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_row_scanout.sv
// Bench for row_scanout on a reduced raster (80x55 totals) so whole frames fit in
// a short run; a spec-level raster model is compared against every output each cycle.
`timescale 1ns/1ps
module tb_row_scanout;

  localparam int A  = 9;
  localparam int S  = 24;
  localparam int R  = 9;
  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 48, VF = 2, VS = 2, VB = 3;
  localparam int SS = 1;
  localparam int SC = 1 << SS;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [A-1:0] address_read;
  logic [S-1:0] data_read = '0;
  logic         swap, line_req, line_done = 1'b0;
  logic [R-1:0] line_row;
  logic [S-1:0] rgb;
  logic         hsync, vsync, de, underrun;

  row_scanout #(
    .A (A), .S (S), .R (R),
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .SCALE_SHIFT (SS)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address_read (address_read),
    .data_read    (data_read),
    .swap         (swap),
    .line_req     (line_req),
    .line_row     (line_row),
    .line_done    (line_done),
    .rgb          (rgb),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .underrun     (underrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int edges = 0;
  always @(posedge clock) edges = reset_n ? edges + 1 : 0;

  task automatic do_reset();
    @(posedge clock); #3;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    reset_n = 1'b1;
  endtask

  // ---------------- row buffer and renderer ----------------
  // Row buffer content is its own address, read with one cycle of latency.
  always @(posedge clock) data_read <= S'(address_read);

  int render_mode  = 0;   // 0: done after render_delay, 1: done in the request cycle only
  int render_delay = 20;
  int done_timer   = 0;
  always @(posedge clock) begin
    #1;
    line_done = 1'b0;
    if (!reset_n) done_timer = 0;
    else if (line_req && render_mode == 1) line_done = 1'b1;
    else if (line_req) done_timer = render_delay;
    else if (done_timer > 0) begin
      done_timer--;
      if (done_timer == 0) line_done = 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t edge=%0d got=%0h expected=%0h", name, $time, edges, act, exp);
    end
  endtask

  // Raster position of the counters after k clock edges since reset release.
  function automatic void hv_at(input int k, output int h, output int v);
    int pos;
    pos = (k + (VT - 2) * HT) % FRAME;
    h = pos % HT;
    v = pos / HT;
  endfunction

  function automatic logic [S-1:0] pixel_at(input int h);
`ifdef SCANOUT_TEST_PATTERN_EN
    logic [S-1:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    return bars[h / (HA / 8)];
`else
    return S'(h >> SS);
`endif
  endfunction

  int row_m = 0;
  bit pend_m = 0, und_m = 0;
  bit win_on = 0;
  int cnt_swap = 0, cnt_req = 0, cnt_hs = 0, cnt_vs = 0, cnt_de = 0;

  always @(negedge clock) begin
    int n, h, v, l;
    bit e_de, e_hs, e_vs, e_swap, e_req;
    logic [S-1:0] e_rgb;
    logic [A-1:0] e_addr;
    if (!reset_n) begin
      check("rst_rgb", 32'(rgb), 0);
      check("rst_de", 32'(de), 0);
      check("rst_hsync", 32'(hsync), 1);
      check("rst_vsync", 32'(vsync), 1);
      check("rst_swap", 32'(swap), 0);
      check("rst_line_req", 32'(line_req), 0);
      check("rst_line_row", 32'(line_row), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_addr", 32'(address_read), 0);
      row_m = 0; pend_m = 0; und_m = 0;
    end else begin
      n = edges;
      hv_at(n, h, v);
      e_addr = (h < HA) ? A'(h >> SS) : '0;
      e_de = 0; e_hs = 1; e_vs = 1; e_rgb = '0;
      if (n >= 2) begin
        hv_at(n - 2, h, v);
        e_de = (h < HA) && (v < VA);
        e_hs = !(h >= HA + HF && h < HA + HF + HS);
        e_vs = !(v >= VA + VF && v < VA + VF + VS);
        if (e_de) e_rgb = pixel_at(h);
      end
      e_swap = 0; e_req = 0;
      if (n >= 1) begin
        hv_at(n - 1, h, v);
        l = (v + 1) % VT;
        if (h == HA && v == VT - 2) begin
          e_req = 1; row_m = 0;
        end else if (h == HA && l < VA && l % SC == 0) begin
          e_swap = 1;
          if (l / SC + 1 < VA / SC) begin
            e_req = 1; row_m = l / SC + 1;
          end
        end
      end
      check("addr", 32'(address_read), 32'(e_addr));
      check("de", 32'(de), 32'(e_de));
      check("hsync", 32'(hsync), 32'(e_hs));
      check("vsync", 32'(vsync), 32'(e_vs));
      check("rgb", 32'(rgb), 32'(e_rgb));
      check("swap", 32'(swap), 32'(e_swap));
      check("line_req", 32'(line_req), 32'(e_req));
      check("line_row", 32'(line_row), 32'(row_m));
      check("underrun", 32'(underrun), 32'(und_m));
      if (e_swap && pend_m) und_m = 1;
      if (e_req) pend_m = 1;
      else if (line_done) pend_m = 0;
      if (win_on) begin
        cnt_swap += int'(swap);
        cnt_req  += int'(line_req);
        cnt_hs   += int'(!hsync);
        cnt_vs   += int'(!vsync);
        cnt_de   += int'(de);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic at_edge(input int n);
    while (edges < n) begin
      @(posedge clock); #2;
    end
  endtask

  // which: 0 line_req, 1 swap, 2 underrun; at_n = -1 if the budget expires.
  task automatic wait_for(input int which, input int budget, output int at_n);
    at_n = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #2;
      if ((which == 0 && line_req) || (which == 1 && swap) || (which == 2 && underrun)) begin
        at_n = edges;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int at_n;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    reset_n = 1'b1;

    // Prime request then first swap one line later, with row 1 requested.
    wait_for(0, 300, at_n);
    check("prime_edge", 32'(at_n), 65);
    check("prime_row", 32'(line_row), 0);
    wait_for(1, 300, at_n);
    check("first_swap_edge", 32'(at_n), 145);
    check("first_swap_req", 32'(line_req), 1);
    check("first_swap_row", 32'(line_row), 1);

    // Top-left pixels appear two clocks after the raster reaches v=0, h=0.
    at_edge(161);
    check("de_before_v0", 32'(de), 0);
    for (int i = 0; i < 6; i++) begin
      at_edge(162 + i);
`ifdef SCANOUT_TEST_PATTERN_EN
      check("rgb_v0_lit", 32'(rgb), 32'h00FFFFFF);
`else
      check("rgb_v0_lit", 32'(rgb), i / 2);
`endif
    end

    // One full frame of pin activity.
    at_edge(200);
    win_on = 1;
    at_edge(200 + FRAME);
    win_on = 0;
    check("frame_swaps", 32'(cnt_swap), 24);
    check("frame_line_req", 32'(cnt_req), 24);
    check("frame_hsync_low", 32'(cnt_hs), 440);
    check("frame_vsync_low", 32'(cnt_vs), 160);
    check("frame_de", 32'(cnt_de), 3072);
    check("frame_no_underrun", 32'(underrun), 0);

    // Slow renderer: a request still pending at the next swap sets underrun.
    render_delay = 200;
    wait_for(2, 1000, at_n);
    check("late_underrun_set", 32'(underrun), 1);
    render_delay = 20;
    repeat (400) @(posedge clock);
    #2;
    check("late_underrun_sticky", 32'(underrun), 1);

    // Done coinciding with the prime request leaves it pending.
    do_reset();
    render_mode = 1;
    wait_for(0, 300, at_n);
    check("same_cycle_prime_edge", 32'(at_n), 65);
    at_edge(150);
    check("same_cycle_underrun", 32'(underrun), 1);
    render_mode = 0;

    // Asynchronous reset mid-line at h=30, v=10, then restart with the prime.
    do_reset();
    at_edge(990);
    check("pre_reset_de", 32'(de), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rgb", 32'(rgb), 0);
    check("async_de", 32'(de), 0);
    check("async_hsync", 32'(hsync), 1);
    check("async_vsync", 32'(vsync), 1);
    check("async_line_row", 32'(line_row), 0);
    check("async_addr", 32'(address_read), 0);
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    reset_n = 1'b1;
    wait_for(0, 300, at_n);
    check("restart_prime_edge", 32'(at_n), 65);
    wait_for(1, 300, at_n);
    check("restart_swap_edge", 32'(at_n), 145);
    repeat (200) @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/row_scanout.md
Name: row_scanout

Overview:
- Downstream consumer of the ping-pong row buffer (double-buffered row memory).
- Generates VGA timing and reads the front row buffer with pixel/line doubling.
- Emits one-cycle `swap` pulses into the row buffer.
- Requests the next source row from the upstream renderer, which writes it into the back buffer. Single clock domain; drives the display pins.

Parameters:
- A, 9, row buffer address width (source row ≤ 2^A pixels)
- S, 24, pixel width (RGB 8:8:8, R in [23:16])
- R, 9, source row index width
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48 — horizontal timing in clocks
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33 — vertical timing in lines
- SCALE_SHIFT, 1, log2 of pixel and line replication factor

Ports:
- clock  in  1  pixel clock; also drives the row buffer read side
- reset_n  in  1  asynchronous, active-low reset
- address_read  out  A  row buffer read address
- data_read  in  S  row buffer read data, valid the cycle after address
- swap  out  1  one-cycle pulse that flips the row buffer front/back
- line_req  out  1  one-cycle pulse asking the renderer to fill the back buffer
- line_row  out  R  source row index for `line_req`, held until the next request
- line_done  in  1  one-cycle pulse from the renderer when the row is complete
- rgb  out  S  pixel out, 0 outside the active area
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  data enable
- underrun  out  1  sticky flag: a swap occurred while a request was still pending

Behaviour:
- Counters
  - h runs 0..H_TOTAL-1; v runs 0..V_TOTAL-1; v increments when h wraps.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Reset (async, reset_n=0)
  - h=0, v=V_TOTAL-2.
  - rgb=0, de=0, hsync=1, vsync=1, swap=0, line_req=0, line_row=0, underrun=0, pending=0.
- Address
  - `address_read = h>>SCALE_SHIFT` while h<H_ACTIVE; 0 otherwise. Combinational from registered h.
- Pipeline (2 cycles)
  - Stage 1 delays the counter-derived de/hsync/vsync by one cycle to align with `data_read`.
  - Stage 2 registers all outputs.
  - Counter state (h,v) at cycle t appears on the pins at t+2.
- Sync and data enable
  - hsync low for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - vsync low for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
  - de = (h<H_ACTIVE) && (v<V_ACTIVE).
- Row boundary
  - Occurs at h==H_ACTIVE on line v where L=(v+1) mod V_TOTAL satisfies L<V_ACTIVE and L mod 2^SCALE_SHIFT == 0.
  - At a row boundary: `swap` pulses.
    - If (L>>SCALE_SHIFT)+1 < V_ACTIVE>>SCALE_SHIFT, `line_req` pulses with `line_row` = that index.
    - Otherwise no request is issued.
- Prime
  - At h==H_ACTIVE on v==V_TOTAL-2, `line_req` pulses with `line_row`=0 and there is no swap.
  - The boundary at v==V_TOTAL-1 then swaps row 0 to the front and requests row 1.
  - The reset values of h and v make the prime the first event after reset.
- Renderer contract: it must finish a row within H_TOTAL clocks. Prime-to-swap is one line; for SCALE_SHIFT>0 the steady-state budget is larger.
- Pending / underrun
  - `line_req` sets pending; `line_done` clears it.
  - If both occur in the same cycle, the new request wins and pending=1.
  - If `swap` fires while pending=1, `underrun` is set and stays set until reset. The swap still fires, so timing is never stalled.
  - `line_done` while pending=0 is ignored.
- Reset asserted mid-frame: outputs go to their reset values immediately. The row buffer swap parity is unknown and needs no correction, because the prime refills the back buffer.

Optional Feature:
- Macro SCANOUT_TEST_PATTERN_EN.
- Defined: `rgb` in the active area = 8 vertical bars, each H_ACTIVE/8 wide, selected by h at stage 1.
  - Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - `data_read` is ignored; swap, line_req, underrun and timing are unchanged.
- Undefined: rgb = data_read registered.

Decomposition:
- Package `vga_timing_pkg`:
  - pixel typedef (S bits)
  - default 640x480@60 timing constants
  - H_TOTAL/V_TOTAL derivation function
  - colour-bar constant array
- Sub-module `vga_timing_counter`: h/v counters, raw hsync/vsync/de, active-area flag.
- All row-boundary, request and output pipeline logic stays in `row_scanout`.

Test Plan:
- Reset then run 2 lines → `line_req` with line_row=0 at the first h=640; `swap` with line_req and line_row=1 exactly 800 clocks later; no swap before it.
- Model a row buffer with 1-cycle latency filled with pixel value = address → at v=0, rgb shows 0,0,1,1,2,2… starting when de first rises, 2 clocks after h=0.
- Count over a full frame → 240 swaps, 240 line_req (prime plus 239), hsync low 96 clocks per line, vsync low 2 lines, 307200 de cycles.
- Withhold `line_done` after a request → `underrun`=1 at the next swap and stays 1; a later `line_done` does not clear it.
- Same-cycle `line_req` and `line_done` → pending stays 1; next swap without a further done sets underrun.
- Assert reset_n=0 mid-line (h=300, v=100) → all outputs at reset values asynchronously; after release the prime request occurs at clock 640.
